// File: rtl/rx_pkt_bcnt_if.sv
// Receive beat stream and count-FIFO write side of rx_pkt_bcnt, with statistics.
// slave is the counter block; master is whatever drives beats and owns the FIFO.
interface rx_pkt_bcnt_if;
   logic        rx_val;
   logic        rx_sop;
   logic        rx_eop;
   logic [2:0]  rx_mod;
   logic        rx_err;
   logic        rx_rdy;
   logic        cnt_wren;
   logic [63:0] cnt_datain;
   logic        cnt_wrfull;
   logic [31:0] pkt_cnt;
   logic [15:0] proto_err_cnt;

   modport master (
      output rx_val, rx_sop, rx_eop, rx_mod, rx_err, cnt_wrfull,
      input  rx_rdy, cnt_wren, cnt_datain, pkt_cnt, proto_err_cnt
   );

   modport slave (
      input  rx_val, rx_sop, rx_eop, rx_mod, rx_err, cnt_wrfull,
      output rx_rdy, cnt_wren, cnt_datain, pkt_cnt, proto_err_cnt
   );
endinterface

// File: rtl/rx_pkt_bcnt.sv
// Per-packet byte counter: accumulates beat sizes and posts one 64-bit descriptor
// per packet into a count FIFO through a one-entry pending register.
module rx_pkt_bcnt #(
   parameter int MAXLEN = 9600,
   parameter int MINLEN = 64
) (
   input logic         clk,
   input logic         reset,
   rx_pkt_bcnt_if.slave bus
);

   typedef enum logic {IDLE, IN_PKT} state_t;

   state_t      state_q, state_d;
   logic [16:0] acc_q, acc_d;
   logic        pend_q;
   logic [18:0] desc_q, desc_d;
   logic [31:0] pkt_cnt_q;
   logic [15:0] perr_q;
   logic        accept;
   logic        load;
   logic        perr_evt;
   logic        wren;
   logic [3:0]  eop_bytes;
   logic [16:0] base;
   logic [16:0] fin_sum;
   logic [15:0] count;

   // Once bit 16 is set the packet is already past 16'hFFFF; freezing keeps it from wrapping.
   function automatic logic [16:0] sat_add(input logic [16:0] a, input logic [3:0] b);
      return a[16] ? a : a + {13'd0, b};
   endfunction

   assign wren        = pend_q & ~bus.cnt_wrfull & ~reset;
   assign bus.rx_rdy  = ~(pend_q & bus.cnt_wrfull);
   assign accept      = bus.rx_val & bus.rx_rdy;
   assign eop_bytes   = (bus.rx_mod == 3'd0) ? 4'd8 : {1'b0, bus.rx_mod};

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      load     = 1'b0;
      perr_evt = 1'b0;
      base     = '0;
      fin_sum  = '0;
      if (accept) begin
         case (state_q)
            IDLE: begin
               if (bus.rx_sop) begin
                  acc_d   = bus.rx_eop ? {13'd0, eop_bytes} : 17'd8;
                  fin_sum = {13'd0, eop_bytes};
                  if (bus.rx_eop) load = 1'b1;
                  else            state_d = IN_PKT;
               end else begin
                  perr_evt = 1'b1;
               end
            end
            IN_PKT: begin
               // A sop here drops the open packet and counts from this beat.
               perr_evt = bus.rx_sop;
               base     = bus.rx_sop ? '0 : acc_q;
               if (bus.rx_eop) begin
                  fin_sum = sat_add(base, eop_bytes);
                  acc_d   = '0;
                  load    = 1'b1;
                  state_d = IDLE;
               end else begin
                  acc_d = sat_add(base, 4'd8);
               end
            end
            default: state_d = IDLE;
         endcase
      end
      count  = fin_sum[16] ? '1 : fin_sum[15:0];
      desc_d = {({1'b0, count} < 17'(MINLEN)), ({1'b0, count} > 17'(MAXLEN)), bus.rx_err, count};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
      end
   end

   // A reload wins over the clear so an eop accepted on the write cycle is never lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q <= 1'b0;
         desc_q <= '0;
      end else if (load) begin
         pend_q <= 1'b1;
         desc_q <= desc_d;
      end else if (wren) begin
         pend_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_cnt_q <= '0;
         perr_q    <= '0;
      end else begin
         if (wren) pkt_cnt_q <= pkt_cnt_q + 32'd1;
         if (perr_evt && (perr_q != '1)) perr_q <= perr_q + 16'd1;
      end
   end

   // The sequence field is the low half of the write counter, so it always tags the entry being written.
   assign bus.cnt_wren      = wren;
   assign bus.cnt_datain    = {16'd0, pkt_cnt_q[15:0], 13'd0, desc_q};
   assign bus.pkt_cnt       = pkt_cnt_q;
   assign bus.proto_err_cnt = perr_q;

endmodule

// File: tb/tb_rx_pkt_bcnt.sv
// Bench for rx_pkt_bcnt: fixed packet table, directed corner sequences and a
// randomized run, all checked against a packet-level reference model.
module tb_rx_pkt_bcnt;
   localparam int MAXLEN = 9600;
   localparam int MINLEN = 64;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rx_pkt_bcnt_if bus();

   rx_pkt_bcnt #(.MAXLEN(MAXLEN), .MINLEN(MINLEN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: packet-level view of the stream.
   bit          m_open;
   int          m_sum;
   bit          m_pend;
   logic [18:0] m_desc;
   logic [31:0] m_pkt;
   logic [15:0] m_perr;

   int          wr_cnt = 0;
   int          stalls = 0;
   logic [63:0] last_desc = '0;
   int          full_left = 0;
   bit          free_full = 0;

   typedef struct {
      int          beats;
      logic [2:0]  mod;
      logic        err;
      logic [15:0] exp_cnt;
      logic [2:0]  exp_flags;  // {runt, trunc, err}
   } vec_t;
   vec_t vt[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_open = 0; m_sum = 0; m_pend = 0; m_desc = '0; m_pkt = '0; m_perr = '0;
   endtask

   task automatic perr_inc();
      if (m_perr != 16'hFFFF) m_perr = m_perr + 16'd1;
   endtask

   task automatic model_beat();
      int bytes;
      int c;
      logic [15:0] c16;
      bytes = bus.rx_eop ? ((bus.rx_mod == 3'd0) ? 8 : int'(bus.rx_mod)) : 8;
      if (bus.rx_sop) begin
         if (m_open) perr_inc();
         m_open = 1;
         m_sum  = bytes;
      end else if (!m_open) begin
         perr_inc();
         return;
      end else begin
         m_sum += bytes;
      end
      if (bus.rx_eop) begin
         c      = (m_sum > 65535) ? 65535 : m_sum;
         c16    = 16'(c);
         m_desc = {(c < MINLEN), (c > MAXLEN), bus.rx_err, c16};
         m_pend = 1;
         m_open = 0;
      end
   endtask

   // One clock: inputs already driven; check at negedge, advance model, return at posedge+1.
   task automatic step(output bit acc);
      bit exp_rdy, exp_wren;
      if (full_left > 0) begin
         bus.cnt_wrfull = 1'b1;
         full_left--;
      end else if (!free_full) begin
         bus.cnt_wrfull = 1'b0;
      end
      @(negedge clk);
      exp_rdy  = !(m_pend && bus.cnt_wrfull);
      exp_wren = m_pend && !bus.cnt_wrfull && !reset;
      chk("rx_rdy", 64'(bus.rx_rdy), 64'(exp_rdy));
      chk("cnt_wren", 64'(bus.cnt_wren), 64'(exp_wren));
      chk("pkt_cnt", 64'(bus.pkt_cnt), 64'(m_pkt));
      chk("proto_err_cnt", 64'(bus.proto_err_cnt), 64'(m_perr));
      if (exp_wren)
         chk("cnt_datain", bus.cnt_datain, {16'd0, m_pkt[15:0], 13'd0, m_desc});
      if (bus.cnt_wren) begin
         wr_cnt++;
         last_desc = bus.cnt_datain;
      end
      if (bus.rx_val && !bus.rx_rdy) stalls++;
      acc = bus.rx_val && exp_rdy && !reset;
      if (reset) begin
         model_reset();
      end else begin
         if (exp_wren) begin
            m_pkt  = m_pkt + 32'd1;
            m_pend = 0;
         end
         if (acc) model_beat();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bit a;
      bus.rx_val = 1'b0;
      for (int i = 0; i < n; i++) step(a);
   endtask

   task automatic beat(input logic sop, input logic eop, input logic [2:0] mod, input logic err);
      bit a;
      int tries = 0;
      bus.rx_val = 1'b1; bus.rx_sop = sop; bus.rx_eop = eop; bus.rx_mod = mod; bus.rx_err = err;
      do begin
         step(a);
         tries++;
      end while (!a && tries < 200);
      if (!a) chk("beat_accept_timeout", 64'd0, 64'd1);
      bus.rx_val = 1'b0;
   endtask

   task automatic send_pkt(input int beats, input logic [2:0] mod, input logic err);
      for (int i = 0; i < beats; i++) begin
         if (i == beats - 1) beat(i == 0, 1'b1, mod, err);
         else                beat(i == 0, 1'b0, 3'($urandom), 1'($urandom));
      end
   endtask

   task automatic do_reset();
      bit a;
      reset = 1'b1;
      bus.rx_val = 1'b0;
      step(a);
      reset = 1'b0;
      chk("rst_cnt_datain", bus.cnt_datain, 64'd0);
      chk("rst_pkt_cnt", 64'(bus.pkt_cnt), 64'd0);
      chk("rst_proto_err_cnt", 64'(bus.proto_err_cnt), 64'd0);
      chk("rst_cnt_wren", 64'(bus.cnt_wren), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, s0, p0;
      bit a;
      vt[0]  = '{8,    3'd4, 1'b0, 16'd60,    3'b100};
      vt[1]  = '{1,    3'd0, 1'b1, 16'd8,     3'b101};
      vt[2]  = '{8,    3'd0, 1'b0, 16'd64,    3'b000};
      vt[3]  = '{8,    3'd7, 1'b0, 16'd63,    3'b100};
      vt[4]  = '{9,    3'd1, 1'b0, 16'd65,    3'b000};
      vt[5]  = '{1200, 3'd0, 1'b0, 16'd9600,  3'b000};
      vt[6]  = '{1201, 3'd1, 1'b0, 16'd9601,  3'b010};
      vt[7]  = '{1250, 3'd0, 1'b1, 16'd10000, 3'b011};
      vt[8]  = '{9000, 3'd0, 1'b0, 16'd65535, 3'b010};
      vt[9]  = '{8192, 3'd0, 1'b0, 16'd65535, 3'b010};
      vt[10] = '{8191, 3'd7, 1'b0, 16'd65527, 3'b010};
      vt[11] = '{1,    3'd5, 1'b0, 16'd5,     3'b100};

      bus.rx_val = 0; bus.rx_sop = 0; bus.rx_eop = 0; bus.rx_mod = 0; bus.rx_err = 0;
      bus.cnt_wrfull = 0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      reset = 1'b0;
      chk("reset_rx_rdy", 64'(bus.rx_rdy), 64'd1);
      chk("reset_cnt_wren", 64'(bus.cnt_wren), 64'd0);
      chk("reset_cnt_datain", bus.cnt_datain, 64'd0);
      chk("reset_pkt_cnt", 64'(bus.pkt_cnt), 64'd0);
      chk("reset_proto_err_cnt", 64'(bus.proto_err_cnt), 64'd0);

      for (int i = 0; i < 12; i++) begin
         w0 = wr_cnt;
         send_pkt(vt[i].beats, vt[i].mod, vt[i].err);
         chk("tbl_no_early_wren", 64'(wr_cnt - w0), 64'd0);
         idle(1);
         chk("tbl_latency", 64'(wr_cnt - w0), 64'd1);
         chk("tbl_count", 64'(last_desc[15:0]), 64'(vt[i].exp_cnt));
         chk("tbl_flags", 64'(last_desc[18:16]), 64'(vt[i].exp_flags));
         chk("tbl_seq", 64'(last_desc[47:32]), 64'(i));
         chk("tbl_reserved", 64'({last_desc[63:48], last_desc[31:19]}), 64'd0);
         chk("tbl_pkt_cnt", 64'(bus.pkt_cnt), 64'(i + 1));
      end

      // FIFO full across an eop with the next packet waiting.
      full_left = 7;
      s0 = stalls; w0 = wr_cnt;
      send_pkt(2, 3'd3, 1'b0);
      send_pkt(2, 3'd0, 1'b0);
      idle(2);
      chk("full_stall_cycles", 64'(stalls - s0), 64'd5);
      chk("full_writes", 64'(wr_cnt - w0), 64'd2);
      chk("full_last_seq", 64'(last_desc[47:32]), 64'd13);

      // sop inside an open packet, then a stray beat in IDLE.
      p0 = int'(bus.proto_err_cnt); w0 = wr_cnt;
      beat(1, 0, 3'd0, 0); beat(0, 0, 3'd0, 0); beat(0, 0, 3'd0, 0);
      beat(1, 0, 3'd0, 0); beat(0, 0, 3'd0, 0); beat(0, 0, 3'd0, 0);
      beat(0, 1, 3'd5, 0);
      beat(0, 0, 3'd0, 0);
      idle(2);
      chk("proto_err_delta", 64'(int'(bus.proto_err_cnt) - p0), 64'd2);
      chk("restart_writes", 64'(wr_cnt - w0), 64'd1);
      chk("restart_count", 64'(last_desc[15:0]), 64'd29);
      chk("restart_flags", 64'(last_desc[18:16]), 64'b100);

      // Back-to-back 2-beat packets.
      s0 = stalls; w0 = wr_cnt;
      for (int i = 0; i < 20; i++) send_pkt(2, 3'($urandom), 1'($urandom));
      idle(1);
      chk("b2b_stalls", 64'(stalls - s0), 64'd0);
      chk("b2b_writes", 64'(wr_cnt - w0), 64'd20);

      // Reset mid-packet abandons it.
      beat(1, 0, 3'd0, 0); beat(0, 0, 3'd0, 0);
      w0 = wr_cnt;
      do_reset();
      beat(0, 1, 3'd0, 0);
      idle(2);
      chk("rst_mid_writes", 64'(wr_cnt - w0), 64'd0);
      chk("rst_mid_pkt_cnt", 64'(bus.pkt_cnt), 64'd0);
      chk("rst_mid_proto_err", 64'(bus.proto_err_cnt), 64'd1);

      // Reset drops a pending descriptor.
      full_left = 3;
      send_pkt(1, 3'd2, 1'b0);
      w0 = wr_cnt;
      do_reset();
      idle(3);
      chk("rst_pend_writes", 64'(wr_cnt - w0), 64'd0);
      chk("rst_pend_pkt_cnt", 64'(bus.pkt_cnt), 64'd0);

      // Randomized traffic against the model.
      free_full = 1;
      for (int i = 0; i < 4000; i++) begin
         reset          = ($urandom_range(0, 599) == 0);
         bus.rx_val     = ($urandom_range(0, 9) < 7);
         bus.rx_sop     = ($urandom_range(0, 7) == 0);
         bus.rx_eop     = ($urandom_range(0, 4) == 0);
         bus.rx_mod     = 3'($urandom);
         bus.rx_err     = 1'($urandom);
         bus.cnt_wrfull = ($urandom_range(0, 3) == 0);
         step(a);
      end
      reset = 1'b0;
      free_full = 0;
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rx_pkt_bcnt.md
RX_PKT_BCNT -- requirements
Module: rx_pkt_bcnt

Interface
REQ-001 The block SHALL have parameter MAXLEN, default 9600, giving the byte count above which a packet is flagged truncated.
REQ-002 The block SHALL have parameter MINLEN, default 64, giving the byte count below which a packet is flagged runt.
REQ-003 The block SHALL have port clk, input, 1, the single clock; it is the wrclk of the downstream count FIFO.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port rx_val, input, 1, the beat-valid signal.
REQ-006 The block SHALL have port rx_sop, input, 1, the first beat of a packet.
REQ-007 The block SHALL have port rx_eop, input, 1, the last beat of a packet.
REQ-008 The block SHALL have port rx_mod, input, 3, the valid bytes on the eop beat; 0 means 8.
REQ-009 The block SHALL have port rx_err, input, 1, the MAC error indication, sampled on the eop beat.
REQ-010 The block SHALL have port rx_rdy, output, 1, the beat-accept signal; a beat transfers when rx_val&rx_rdy.
REQ-011 The block SHALL have port cnt_wren, output, 1, the count FIFO write enable.
REQ-012 The block SHALL have port cnt_datain, output, 64, the count descriptor.
REQ-013 The block SHALL have port cnt_wrfull, input, 1, the count FIFO full flag.
REQ-014 The block SHALL have port pkt_cnt, output, 32, the number of descriptors written.
REQ-015 The block SHALL have port proto_err_cnt, output, 16, the saturating count of protocol errors.

Function
REQ-016 The state machine SHALL have states IDLE and IN_PKT.
REQ-017 In IDLE, an accepted beat with rx_sop SHALL load the accumulator with 8 (or the rx_mod value if rx_eop is also set) and move to IN_PKT, unless rx_eop is also set.
REQ-018 In IN_PKT, each accepted non-eop beat SHALL add 8, and an eop beat SHALL add rx_mod (0 counts as 8) and return to IDLE.
REQ-019 The accumulator SHALL be 17 bits wide, and the reported count SHALL saturate at 16'hFFFF.
REQ-020 The descriptor SHALL be: [15:0] byte count, [16] rx_err, [17] count>MAXLEN, [18] count<MINLEN, [31:19] zero, [47:32] 16-bit wrapping sequence number, [63:48] zero.
REQ-021 On an accepted eop beat, the descriptor SHALL be loaded into a one-entry pending register at the next clock edge.
REQ-022 cnt_wren SHALL equal pend & ~cnt_wrfull, and cnt_datain SHALL be the pending register contents.
REQ-023 pend SHALL clear on the edge where cnt_wren=1, unless a new eop is accepted on the same cycle, in which case the pending register reloads.
REQ-024 rx_rdy SHALL equal ~(pend & cnt_wrfull); no descriptor is ever lost or overwritten.
REQ-025 The sequence number and pkt_cnt SHALL each increment by 1 on every cnt_wren, and both wrap.
REQ-026 An accepted sop in IN_PKT SHALL discard the open packet, increment proto_err_cnt, and restart the count with this beat.
REQ-027 An accepted beat without sop in IDLE SHALL be ignored and SHALL increment proto_err_cnt.
REQ-028 proto_err_cnt SHALL saturate at 16'hFFFF.
REQ-029 A beat with rx_val=0, or with rx_rdy=0, SHALL have no effect.
REQ-030 Latency SHALL be one cycle from the accepted eop beat to cnt_wren when cnt_wrfull=0.

Reset
REQ-031 While reset=1 at a clock edge, the block SHALL apply state=IDLE, accumulator=0, pend=0, cnt_wren=0, cnt_datain=0, rx_rdy=1, sequence=0, pkt_cnt=0, proto_err_cnt=0.
REQ-032 Reset asserted mid-packet SHALL abandon that packet and SHALL NOT produce a descriptor.
REQ-033 A pending descriptor not yet written when reset is asserted SHALL be dropped.

Verification
REQ-034 Scenario: 8 beats, sop on beat 0, eop on beat 7 with rx_mod=4 -> one cnt_wren, one cycle after eop, with cnt_datain[15:0]=60, [18]=1, [47:32]=0.
REQ-035 Scenario: single beat with sop, eop and rx_mod=0, rx_err=1 -> count=8, [16]=1, [18]=1; pkt_cnt=1.
REQ-036 Scenario: cnt_wrfull=1 held for 5 cycles across an eop, with the next packet's beats offered -> rx_rdy stays 0 while pend; the descriptor is written the first cycle wrfull=0; nothing is lost and sequence numbers are consecutive.
REQ-037 Scenario: 1250 beats with rx_mod=0 -> count=10000, [17]=1; 9000 beats -> count=65535 (saturated).
REQ-038 Scenario: sop at beat 3 of an open packet, then a beat without sop in IDLE -> proto_err_cnt=2, and exactly one descriptor for the restarted packet.
REQ-039 Scenario: back-to-back 2-beat packets with cnt_wrfull=0 -> rx_rdy stays 1 throughout, and one cnt_wren per packet.
